// File: rtl/rr_mux_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package rr_mux_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    onehot2idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) onehot2idx = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Single-bit 4:1 multiplexer cell.
module mux_4_to_1 (
  output logic       out,
  input  logic [3:0] in,
  input  logic [1:0] sel
);

  assign out = in[sel];

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at or after start, wrapping mod 4.
module rr_pick
  import rr_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   first;

  // Rotate so start lands at bit 0, isolate the lowest set bit, then add start back.
  always_comb begin
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    first = rot & (~rot + NUM_REQ'(1));
    found = |req;
    idx   = onehot2idx(first) + start;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a shared 4:1 data mux with a bounded hold tenure.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]         sel,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  state_t             state, state_next;
  logic [SEL_W-1:0]   ptr, ptr_next, sel_next, start, win;
  logic [NUM_REQ-1:0] gnt_next, pick_req;
  logic [CW-1:0]      hold_cnt, hold_next;
  logic               valid_next, found, grant;
  logic [WIDTH-1:0]   mux_out;

  // While holding, the owner is excluded and the search resumes just past it.
  assign pick_req = (state == HOLD) ? (req & ~gnt) : req;
  assign start    = (state == HOLD) ? sel + SEL_W'(1) : ptr;

  rr_pick u_pick (
    .req   (pick_req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    sel_next   = sel;
    valid_next = valid;
    ptr_next   = ptr;
    hold_next  = hold_cnt;
    grant      = 1'b0;
    case (state)
      IDLE: grant = found;
      HOLD: begin
        if (!(|(req & gnt))) begin
          if (found) begin
            grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            valid_next = 1'b0;
          end
        end else if (hold_cnt == HOLD_MAX && found) begin
          grant = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_next = hold_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (grant) begin
      state_next = HOLD;
      gnt_next   = NUM_REQ'(1) << win;
      sel_next   = onehot2idx(gnt_next);
      valid_next = 1'b1;
      hold_next  = CW'(1);
      ptr_next   = win + SEL_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      sel      <= sel_next;
      valid    <= valid_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux_4_to_1 u_mux (
      .out (mux_out[b]),
      .in  ({din[3*WIDTH+b], din[2*WIDTH+b], din[WIDTH+b], din[b]}),
      .sel (sel)
    );
  end

  assign dout = valid ? mux_out : '0;

endmodule
